seq_ctrl_conditioner: RTL and testbench
=======================================

Name: seq_ctrl_conditioner

Overview:
Upstream control stage for the five-state sequencer FSM. It turns raw board inputs into the sequencer's clean synchronous controls:
- two active-low push buttons (pause, restart) and one slide switch (goto_third);
- each input is synchronized, then debounced; buttons are also edge-detected.

It also counts completed sequence passes by watching the sequencer's terminal flag.

Parameters:
DB_CYCLES, 4, consecutive cycles a synchronized input must differ from its debounced value before the debounced value updates; legal range 2..65535.
CNT_W, 8, width of run_count.

Ports:
clk  input  1  system clock; all flops rising-edge.
rst  input  1  asynchronous, active-high reset.
btn_pause_n  input  1  raw pause button, active-low, asynchronous to clk, may bounce.
btn_restart_n  input  1  raw restart button, active-low, asynchronous, may bounce.
sw_goto_third  input  1  raw switch, active-high, asynchronous, may bounce.
terminal_in  input  1  sequencer terminal flag, synchronous to clk; high for one cycle per pass through the last state.
pause  output  1  level to sequencer; toggles on each debounced pause press.
restart  output  1  one-cycle pulse to sequencer on each debounced restart press.
goto_third  output  1  debounced switch level to sequencer.
run_count  output  CNT_W  number of completed passes (terminal_in rising edges); saturating.

Behaviour:
- Reset (rst high, async): pause=0, restart=0, goto_third=0, run_count=0.
  - Synchronizer and debounced button registers reset to released (1); switch registers reset to 0.
  - Debounce counters reset to 0; all edge-detect delay registers reset to their inactive value.
- Synchronizer: each raw input goes through 2 flops.
- Debouncer, one instance per input, counter width clog2(DB_CYCLES):
  - If sync != stable: when cnt == DB_CYCLES-1, stable<=sync and cnt<=0; otherwise cnt<=cnt+1.
  - If sync == stable: cnt<=0.
  - Any bounce shorter than DB_CYCLES cycles leaves stable unchanged.
- Press event: a debounced button goes released->pressed, detected against a one-cycle-delayed copy. Release events generate nothing.
- Latency: raw button first sampled low at edge E, held low -> stable changes at edge E+DB_CYCLES+1 -> press registered at edge E+DB_CYCLES+2.
- restart: restart<=restart_press. High exactly one cycle per press, regardless of hold time.
- pause update at each edge, in priority order:
  - restart_press: pause<=0.
  - else pause_press: pause<=~pause.
  - else hold.
  - A simultaneous pause and restart press therefore gives pause=0, and the pause press is discarded.
- goto_third: equals the debounced switch value directly. Latency is E+DB_CYCLES+1 for a change first sampled at edge E.
- run_count:
  - Rising edge of terminal_in, detected with a 1-flop delay, no synchronizer: increment at the same edge terminal_in is first seen high.
  - Saturate at 2^CNT_W-1.
  - restart_press at the same edge clears run_count to 0; the clear beats the increment.
- Reset mid-operation: all state clears immediately.
  - A button still held through reset release produces one press event DB_CYCLES+2 edges after the first post-reset edge, because stable restarts as released.
  - A switch held high through reset release reaches goto_third=1 after DB_CYCLES+1 edges.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
Run with DB_CYCLES=4, CNT_W=8.
1. Reset, then hold all inputs inactive 20 cycles -> pause=0, restart=0, goto_third=0, run_count=0 throughout.
2. btn_restart_n low from edge 10, held 30 cycles -> restart high only in the cycle after edge 16; no further pulse during hold or on release.
3. btn_pause_n bounces low 2 cycles / high 1 cycle three times, then settles low -> pause toggles 0->1 exactly once, 6 edges after the settling sample; a second clean press returns pause to 0.
4. With pause=1, press pause and restart so raw lows are sampled on the same edge -> one restart pulse; pause=0 after the event edge.
5. Drive terminal_in high for one cycle every 5 cycles, 300 times -> run_count saturates at 255. A restart press -> run_count=0 at the restart edge; a terminal pulse on that same edge does not increment it.
6. sw_goto_third high, assert rst for 3 cycles mid-operation with the switch still high -> goto_third=0 immediately on rst; goto_third=1 five edges after the first post-reset edge.

Source files
------------

// File: rtl/seq_ctrl_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : seq_ctrl_conditioner
// Description : Input conditioning ahead of the five-state sequencer.
//               Each raw board input is passed through a 2-flop synchronizer
//               and a counter-based debouncer. The push buttons are also
//               edge-detected to produce press events. Completed sequence
//               passes are counted from the sequencer's terminal flag.
//
// Ports       : clk            system clock, rising edge
//               rst            asynchronous active-high reset
//               btn_pause_n    raw pause button (active-low, async, bouncy)
//               btn_restart_n  raw restart button (active-low, async, bouncy)
//               sw_goto_third  raw slide switch (active-high, async, bouncy)
//               terminal_in    sequencer terminal flag (synchronous pulse)
//               pause          toggles on each debounced pause press
//               restart        one-cycle pulse per debounced restart press
//               goto_third     debounced switch level
//               run_count      saturating count of terminal_in rising edges
//
// Revision    : 1.0  initial release
// ============================================================================
module seq_ctrl_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_pause_n,
  input  logic             btn_restart_n,
  input  logic             sw_goto_third,
  input  logic             terminal_in,
  output logic             pause,
  output logic             restart,
  output logic             goto_third,
  output logic [CNT_W-1:0] run_count
);

  localparam int c_n_ch = 3;
  localparam int c_cw   = $clog2(DB_CYCLES);

  localparam logic [c_cw-1:0]  c_cnt_max = c_cw'(DB_CYCLES - 1);
  localparam logic [c_cw-1:0]  c_cnt_one = c_cw'(1);
  localparam logic [CNT_W-1:0] c_run_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_run_sat = '1;

  // Channel order: 0 = pause button, 1 = restart button, 2 = switch.
  // Buttons idle released (high); the switch idles low.
  localparam logic [c_n_ch-1:0] c_rst_val = 3'b011;

  logic [c_n_ch-1:0] w_raw;
  logic [c_n_ch-1:0] w_stable;

  assign w_raw = {sw_goto_third, btn_restart_n, btn_pause_n};

  // --------------------------------------------------------------------------
  // Synchronizer + debouncer per input. The stable value only follows the
  // synchronized input after DB_CYCLES consecutive disagreeing cycles; any
  // agreeing cycle restarts the count.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < c_n_ch; g++) begin : g_ch
    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable;
    logic [c_cw-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync1  <= c_rst_val[g];
        r_sync2  <= c_rst_val[g];
        r_stable <= c_rst_val[g];
        r_cnt    <= '0;
      end else begin
        r_sync1 <= w_raw[g];
        r_sync2 <= r_sync1;
        if (r_sync2 != r_stable) begin
          if (r_cnt == c_cnt_max) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    assign w_stable[g] = r_stable;
  end

  // --------------------------------------------------------------------------
  // Press detection: released (1) in the previous cycle, pressed (0) now.
  // --------------------------------------------------------------------------
  logic [1:0] r_btn_prev;
  logic       w_pause_press;
  logic       w_restart_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_prev <= 2'b11;
    end else begin
      r_btn_prev <= w_stable[1:0];
    end
  end

  assign w_pause_press   = r_btn_prev[0] & ~w_stable[0];
  assign w_restart_press = r_btn_prev[1] & ~w_stable[1];

  // --------------------------------------------------------------------------
  // Pause level and restart pulse. Restart has priority over a pause toggle
  // landing on the same edge, so the pause press is dropped.
  // --------------------------------------------------------------------------
  logic r_pause;
  logic r_restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pause   <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_restart <= w_restart_press;
      if (w_restart_press) begin
        r_pause <= 1'b0;
      end else if (w_pause_press) begin
        r_pause <= ~r_pause;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pass counter. terminal_in is already synchronous, so it is edge-detected
  // directly and counted on the same edge it is first seen high.
  // --------------------------------------------------------------------------
  logic             r_term_d;
  logic [CNT_W-1:0] r_run_count;
  logic             w_term_rise;

  assign w_term_rise = terminal_in & ~r_term_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_term_d    <= 1'b0;
      r_run_count <= '0;
    end else begin
      r_term_d <= terminal_in;
      if (w_restart_press) begin
        r_run_count <= '0;
      end else if (w_term_rise && (r_run_count != c_run_sat)) begin
        r_run_count <= r_run_count + c_run_one;
      end
    end
  end

  assign pause      = r_pause;
  assign restart    = r_restart;
  assign goto_third = w_stable[2];
  assign run_count  = r_run_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_ctrl_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_ctrl_conditioner
// Description : Directed self-checking bench for seq_ctrl_conditioner with
//               DB_CYCLES=4, CNT_W=8. Inputs change 1 time unit after a
//               rising edge; outputs are observed at the same point.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_ctrl_conditioner;

  logic       clk;
  logic       rst;
  logic       btn_pause_n;
  logic       btn_restart_n;
  logic       sw_goto_third;
  logic       terminal_in;
  logic       pause;
  logic       restart;
  logic       goto_third;
  logic [7:0] run_count;

  int n_checks;
  int n_pass;

  seq_ctrl_conditioner #(
    .DB_CYCLES (4),
    .CNT_W     (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_pause_n   (btn_pause_n),
    .btn_restart_n (btn_restart_n),
    .sw_goto_third (sw_goto_third),
    .terminal_in   (terminal_in),
    .pause         (pause),
    .restart       (restart),
    .goto_third    (goto_third),
    .run_count     (run_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    btn_pause_n   = 1'b1;
    btn_restart_n = 1'b1;
    sw_goto_third = 1'b0;
    terminal_in   = 1'b0;

    // Reset state
    idle(3);
    chk("rst_pause", pause, 0);
    chk("rst_restart", restart, 0);
    chk("rst_goto", goto_third, 0);
    chk("rst_count", run_count, 0);
    rst = 1'b0;

    // 1. Idle inputs keep everything inactive
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("idle_pause", pause, 0);
      chk("idle_restart", restart, 0);
      chk("idle_goto", goto_third, 0);
      chk("idle_count", run_count, 0);
    end

    // 2. Held restart: one pulse, DB_CYCLES+2 edges after first sample
    btn_restart_n = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("restart_hold", restart, (k == 6) ? 1 : 0);
    end
    btn_restart_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("restart_release", restart, 0);
    end
    chk("restart_pause", pause, 0);

    // 3. Bouncing pause press, then settle low
    for (int r = 0; r < 3; r++) begin
      btn_pause_n = 1'b0; tick(); chk("bounce_pause", pause, 0);
      tick(); chk("bounce_pause", pause, 0);
      btn_pause_n = 1'b1; tick(); chk("bounce_pause", pause, 0);
    end
    btn_pause_n = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("settle_pause", pause, (k >= 6) ? 1 : 0);
    end
    btn_pause_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("pause_release", pause, 1);
    end
    btn_pause_n = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("pause_second", pause, (k < 6) ? 1 : 0);
    end
    btn_pause_n = 1'b1;
    idle(10);

    // 4. Simultaneous presses with pause=1, then with pause=0
    btn_pause_n = 1'b0;
    idle(8);
    chk("pre_sim_pause", pause, 1);
    btn_pause_n = 1'b1;
    idle(10);
    btn_pause_n   = 1'b0;
    btn_restart_n = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("sim1_restart", restart, (k == 6) ? 1 : 0);
      chk("sim1_pause", pause, (k < 6) ? 1 : 0);
    end
    btn_pause_n   = 1'b1;
    btn_restart_n = 1'b1;
    idle(10);
    btn_pause_n   = 1'b0;
    btn_restart_n = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("sim0_restart", restart, (k == 6) ? 1 : 0);
      chk("sim0_pause", pause, 0);
    end
    btn_pause_n   = 1'b1;
    btn_restart_n = 1'b1;
    idle(10);

    // 5. Terminal pulses saturate the counter
    for (int i = 0; i < 300; i++) begin
      terminal_in = 1'b1;
      tick();
      chk("count_incr", run_count, (i + 1 > 255) ? 255 : i + 1);
      terminal_in = 1'b0;
      idle(4);
    end
    chk("count_sat", run_count, 255);

    // Restart clear beats a coincident terminal rise
    btn_restart_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("count_pre_clear", run_count, 255);
    end
    terminal_in = 1'b1;
    tick();
    chk("clear_restart", restart, 1);
    chk("clear_count", run_count, 0);
    terminal_in = 1'b0;
    tick();
    chk("clear_hold", run_count, 0);
    terminal_in = 1'b1;
    tick();
    chk("post_clear_incr", run_count, 1);
    terminal_in = 1'b0;
    btn_restart_n = 1'b1;
    idle(10);
    chk("post_clear_keep", run_count, 1);

    // 6. Switch latency, then reset mid-operation with switch and pause held
    sw_goto_third = 1'b1;
    btn_pause_n   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("sw_latency", goto_third, (k >= 5) ? 1 : 0);
      chk("held_pause", pause, (k >= 6) ? 1 : 0);
    end
    rst = 1'b1;
    #1;
    chk("async_rst_goto", goto_third, 0);
    chk("async_rst_pause", pause, 0);
    chk("async_rst_count", run_count, 0);
    idle(3);
    chk("rst_hold_goto", goto_third, 0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("post_rst_goto", goto_third, (k >= 5) ? 1 : 0);
      chk("post_rst_pause", pause, (k >= 6) ? 1 : 0);
      chk("post_rst_restart", restart, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
